// File: rtl/switch_mcu_alu_pkg.sv
// Shared encodings for the switch MCU shift unit: op codes, FSM states, x0 index.
package switch_mcu_alu_pkg;
  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [2:0] {IDLE, READ, WAIT, SHIFT, WRITE} state_e;

  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/switch_mcu_shift_step.sv
// One combinational shift step of up to STEP bits; the caller supplies the fill bit.
module switch_mcu_shift_step
  import switch_mcu_alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NW   = 6
) (
  input  op_e              in_op,
  input  logic [XLEN-1:0]  in_data,
  input  logic [NW-1:0]    in_n,
  input  logic             in_fill,
  output logic [XLEN-1:0]  out_data
);
  always_comb begin
    out_data = in_data;
    case (in_op)
      OP_SLL:  out_data = in_data << in_n;
      OP_SRL,
      OP_SRA:  out_data = XLEN'({{XLEN{in_fill}}, in_data} >> in_n);
      OP_ROR:  out_data = XLEN'({in_data, in_data} >> in_n);
      default: out_data = in_data;
    endcase
  end
endmodule

// File: rtl/switch_mcu_alu_shift.sv
// Iterative shift execution unit: reads rs1 (and rs2), shifts STEP bits/cycle, writes rd.
// Define SWITCH_MCU_SHIFT_ROT_EN to make op 11 a rotate-right; otherwise it is illegal.
module switch_mcu_alu_shift
  import switch_mcu_alu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int STEP        = 8,
  parameter int REGFILE_LAT = 1
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_en,
  input  logic            in_start,
  input  logic [1:0]      in_op,
  input  logic            in_use_imm,
  input  logic [11:0]     in_imm_type_i,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_rdata_1,
  input  logic [XLEN-1:0] in_rdata_2,
  output logic [4:0]      out_raddr_1,
  output logic [4:0]      out_raddr_2,
  output logic            out_ren_1,
  output logic            out_ren_2,
  output logic [4:0]      out_waddr,
  output logic            out_wen,
  output logic [XLEN-1:0] out_wdata,
  output logic            out_busy,
  output logic            out_done,
  output logic            out_illegal
);
  localparam int SHAMT_W = $clog2(XLEN);
  localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W+1)'(STEP);
`ifdef SWITCH_MCU_SHIFT_ROT_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  state_e               state;
  op_e                  op_q;
  logic                 use_imm_q;
  logic [SHAMT_W-1:0]   imm_sh_q;
  logic [4:0]           rd_q;
  logic [2:0]           wait_cnt;
  logic [XLEN-1:0]      opnd;
  logic [SHAMT_W-1:0]   rem;

  logic [SHAMT_W-1:0]   shamt_src;
  logic                 illegal_op;
  logic [SHAMT_W:0]     rem_x;
  logic [SHAMT_W:0]     n;
  logic                 last_step;
  logic                 fill;
  logic [XLEN-1:0]      shifted;
  logic                 unused_bits;

  // Only the low SHAMT_W bits of the shift amount source matter.
  assign shamt_src   = use_imm_q ? imm_sh_q : in_rdata_2[SHAMT_W-1:0];
  assign unused_bits = ^{in_imm_type_i[11:SHAMT_W], in_rdata_2[XLEN-1:SHAMT_W]};
  assign illegal_op  = (op_q == OP_ROR) && !ROT_EN;
  assign rem_x       = {1'b0, rem};
  assign last_step   = (rem_x <= STEP_W);
  assign n           = last_step ? rem_x : STEP_W;
  assign fill        = (op_q == OP_SRA) & opnd[XLEN-1];

  switch_mcu_shift_step #(.XLEN(XLEN), .NW(SHAMT_W+1)) u_step (
    .in_op    (op_q),
    .in_data  (opnd),
    .in_n     (n),
    .in_fill  (fill),
    .out_data (shifted)
  );

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state       <= IDLE;
      op_q        <= OP_SLL;
      use_imm_q   <= 1'b0;
      imm_sh_q    <= '0;
      rd_q        <= '0;
      wait_cnt    <= '0;
      opnd        <= '0;
      rem         <= '0;
      out_raddr_1 <= '0;
      out_raddr_2 <= '0;
      out_ren_1   <= 1'b0;
      out_ren_2   <= 1'b0;
      out_waddr   <= '0;
      out_wen     <= 1'b0;
      out_wdata   <= '0;
      out_busy    <= 1'b0;
      out_done    <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      out_raddr_1 <= '0;
      out_raddr_2 <= '0;
      out_ren_1   <= 1'b0;
      out_ren_2   <= 1'b0;
      out_waddr   <= '0;
      out_wen     <= 1'b0;
      out_wdata   <= '0;
      out_done    <= 1'b0;
      out_illegal <= 1'b0;
      if (!in_en) begin
        // Abort: drop back to idle without writing or signalling completion.
        state    <= IDLE;
        out_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (in_start) begin
            op_q        <= op_e'(in_op);
            use_imm_q   <= in_use_imm;
            imm_sh_q    <= in_imm_type_i[SHAMT_W-1:0];
            rd_q        <= in_rd;
            out_ren_1   <= 1'b1;
            out_raddr_1 <= in_rs1;
            out_ren_2   <= !in_use_imm;
            out_raddr_2 <= in_use_imm ? 5'd0 : in_rs2;
            out_busy    <= 1'b1;
            state       <= READ;
          end
          READ: begin
            wait_cnt <= 3'(REGFILE_LAT - 1);
            state    <= WAIT;
          end
          WAIT: begin
            if (wait_cnt != 3'd0) begin
              wait_cnt <= wait_cnt - 3'd1;
            end else begin
              opnd <= in_rdata_1;
              rem  <= shamt_src;
              if (shamt_src == '0 || illegal_op) begin
                out_waddr   <= rd_q;
                out_wdata   <= illegal_op ? '0 : in_rdata_1;
                out_wen     <= (rd_q != REG_X0) && !illegal_op;
                out_done    <= 1'b1;
                out_illegal <= illegal_op;
                state       <= WRITE;
              end else begin
                state <= SHIFT;
              end
            end
          end
          SHIFT: begin
            opnd <= shifted;
            rem  <= rem - n[SHAMT_W-1:0];
            if (last_step) begin
              out_waddr <= rd_q;
              out_wdata <= shifted;
              out_wen   <= (rd_q != REG_X0);
              out_done  <= 1'b1;
              state     <= WRITE;
            end
          end
          WRITE: begin
            out_busy <= 1'b0;
            state    <= IDLE;
          end
          default: begin
            out_busy <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_switch_mcu_alu_shift.sv
// Directed bench for the shift unit: default build plus a 64-bit, STEP=1, LAT=2 instance.
module tb_switch_mcu_alu_shift;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, start, rst_b, en_b, start_b;
  logic [1:0]  op;
  logic        use_imm;
  logic [11:0] imm;
  logic [4:0]  rs1, rs2, rd;

  logic [31:0] rdata_1, rdata_2, wdata;
  logic [4:0]  raddr_1, raddr_2, waddr;
  logic        ren_1, ren_2, wen, busy, done, illegal;

  logic [63:0] rdata_1b, rdata_2b, wdata_b;
  logic [4:0]  raddr_1b, raddr_2b, waddr_b;
  logic        ren_1b, ren_2b, wen_b, busy_b, done_b, illegal_b;

  logic [63:0] rf [32];

  switch_mcu_alu_shift dut (
    .in_clk(clk), .in_rst(rst), .in_en(en), .in_start(start), .in_op(op),
    .in_use_imm(use_imm), .in_imm_type_i(imm), .in_rs1(rs1), .in_rs2(rs2), .in_rd(rd),
    .in_rdata_1(rdata_1), .in_rdata_2(rdata_2), .out_raddr_1(raddr_1), .out_raddr_2(raddr_2),
    .out_ren_1(ren_1), .out_ren_2(ren_2), .out_waddr(waddr), .out_wen(wen), .out_wdata(wdata),
    .out_busy(busy), .out_done(done), .out_illegal(illegal));

  switch_mcu_alu_shift #(.XLEN(64), .STEP(1), .REGFILE_LAT(2)) dut64 (
    .in_clk(clk), .in_rst(rst_b), .in_en(en_b), .in_start(start_b), .in_op(op),
    .in_use_imm(use_imm), .in_imm_type_i(imm), .in_rs1(rs1), .in_rs2(rs2), .in_rd(rd),
    .in_rdata_1(rdata_1b), .in_rdata_2(rdata_2b), .out_raddr_1(raddr_1b), .out_raddr_2(raddr_2b),
    .out_ren_1(ren_1b), .out_ren_2(ren_2b), .out_waddr(waddr_b), .out_wen(wen_b), .out_wdata(wdata_b),
    .out_busy(busy_b), .out_done(done_b), .out_illegal(illegal_b));

  // Register file models: data is valid for exactly one cycle, REGFILE_LAT after the enable.
  logic       v1a, v2a;
  logic [4:0] q1a, q2a;
  logic [1:0] v1b, v2b;
  logic [4:0] q1b [2];
  logic [4:0] q2b [2];
  always @(posedge clk) begin
    v1a <= ren_1;  q1a <= raddr_1;
    v2a <= ren_2;  q2a <= raddr_2;
    v1b <= {v1b[0], ren_1b};  q1b[1] <= q1b[0];  q1b[0] <= raddr_1b;
    v2b <= {v2b[0], ren_2b};  q2b[1] <= q2b[0];  q2b[0] <= raddr_2b;
  end
  assign rdata_1  = v1a ? rf[q1a][31:0] : 32'hDEAD_BEEF;
  assign rdata_2  = v2a ? rf[q2a][31:0] : 32'hDEAD_BEEF;
  assign rdata_1b = v1b[1] ? rf[q1b[1]] : 64'hDEAD_BEEF_DEAD_BEEF;
  assign rdata_2b = v2b[1] ? rf[q2b[1]] : 64'hDEAD_BEEF_DEAD_BEEF;

  int nvec = 0, nfail = 0;
  int lat, r2;
  logic wen_s, ill_s;
  logic [31:0] wd_s;
  logic [4:0] wa_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run32(input logic [1:0] o, input logic ui, input logic [11:0] im,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    @(negedge clk);
    op = o; use_imm = ui; imm = im; rs1 = s1; rs2 = s2; rd = d; start = 1'b1;
    lat = -1; r2 = 0; wen_s = 1'b0; ill_s = 1'b0; wd_s = '0; wa_s = '0;
    for (int e = 1; e <= 60; e++) begin
      @(negedge clk);
      start = 1'b0;
      if (ren_2) r2++;
      if (done) begin
        lat = e; wen_s = wen; wd_s = wdata; ill_s = illegal; wa_s = waddr;
        break;
      end
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1; rst_b = 1'b1; en = 1'b1; en_b = 1'b1; start = 1'b0; start_b = 1'b0;
    op = 2'b00; use_imm = 1'b0; imm = '0; rs1 = '0; rs2 = '0; rd = '0;
    for (int i = 0; i < 32; i++) rf[i] = 64'hC3C3_C3C3_0000_0100 + 64'(i);
    rf[1] = 64'h1;
    rf[2] = 64'h8000_0000;
    rf[3] = 64'hFFFF_FFE4;
    rf[4] = 64'h1234_5678;
    rf[5] = 64'hF1;

    repeat (2) @(negedge clk);
    chk("reset_ctl", {busy, done, wen, ren_1, ren_2, illegal}, 64'd0);
    chk("reset_data", {wdata, raddr_1, raddr_2, waddr}, 64'd0);
    rst = 1'b0; rst_b = 1'b0;

    run32(2'b00, 1'b1, 12'd31, 5'd1, 5'd0, 5'd7);
    chk("sll31_lat", 64'(lat), 64'd7);
    chk("sll31_data", {31'd0, wen_s, wa_s, wd_s}, {31'd0, 1'b1, 5'd7, 32'h8000_0000});
    chk("sll31_ren2", 64'(r2), 64'd0);
    @(negedge clk);
    chk("idle_after_done", {busy, done, wen}, 64'd0);

    run32(2'b10, 1'b0, 12'd0, 5'd2, 5'd3, 5'd8);
    chk("sra_reg_lat", 64'(lat), 64'd4);
    chk("sra_reg_data", {wen_s, wd_s}, {1'b1, 32'hF800_0000});
    chk("sra_reg_ren2", 64'(r2), 64'd1);

    run32(2'b01, 1'b1, 12'd0, 5'd4, 5'd0, 5'd9);
    chk("srl0_lat", 64'(lat), 64'd3);
    chk("srl0_data", {wen_s, wd_s}, {1'b1, 32'h1234_5678});

    run32(2'b01, 1'b1, 12'd0, 5'd4, 5'd0, 5'd0);
    chk("rd0_lat", 64'(lat), 64'd3);
    chk("rd0_nowen", {wen_s, ill_s}, 64'd0);

    run32(2'b01, 1'b1, 12'hFE4, 5'd2, 5'd0, 5'd10);
    chk("imm_hi_ignored", {64'(lat), wd_s}, {64'd4, 32'h0800_0000});

    run32(2'b10, 1'b1, 12'd31, 5'd2, 5'd0, 5'd11);
    chk("sra31", {64'(lat), wd_s}, {64'd7, 32'hFFFF_FFFF});

    run32(2'b11, 1'b1, 12'd4, 5'd5, 5'd0, 5'd12);
`ifdef SWITCH_MCU_SHIFT_ROT_EN
    chk("ror_lat", 64'(lat), 64'd4);
    chk("ror_data", {wen_s, ill_s, wd_s}, {1'b1, 1'b0, 32'h1000_000F});
`else
    chk("op11_lat", 64'(lat), 64'd3);
    chk("op11_illegal", {wen_s, ill_s}, {1'b0, 1'b1});
`endif

    // Abort in SHIFT: clear everything on the next edge and never complete.
    @(negedge clk);
    op = 2'b00; use_imm = 1'b1; imm = 12'd31; rs1 = 5'd1; rd = 5'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    en = 1'b0;
    @(negedge clk);
    chk("abort_ctl", {busy, done, wen, ren_1, ren_2, illegal}, 64'd0);
    chk("abort_data", {wdata, waddr}, 64'd0);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || wen || busy) cnt++;
    end
    chk("abort_quiet", 64'(cnt), 64'd0);
    en = 1'b1;
    run32(2'b00, 1'b1, 12'd31, 5'd1, 5'd0, 5'd13);
    chk("after_abort", {64'(lat), wen_s, wd_s}, {64'd7, 1'b1, 32'h8000_0000});

    // 64-bit, STEP=1, REGFILE_LAT=2 instance.
    @(negedge clk);
    op = 2'b00; use_imm = 1'b1; imm = 12'd63; rs1 = 5'd1; rd = 5'd5; start_b = 1'b1;
    lat = -1;
    for (int e = 1; e <= 100; e++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (done_b) begin
        lat = e; wen_s = wen_b; wa_s = waddr_b;
        chk("w64_data", wdata_b, 64'h8000_0000_0000_0000);
        break;
      end
    end
    chk("w64_lat", 64'(lat), 64'd67);
    chk("w64_wen", {wen_s, wa_s}, {1'b1, 5'd5});

    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (9) @(negedge clk);
    chk("w64_busy_mid", 64'(busy_b), 64'd1);
    #1 rst_b = 1'b1;
    #1;
    chk("w64_async_rst", {busy_b, done_b, wen_b, ren_1b, ren_2b, illegal_b, waddr_b}, 64'd0);
    chk("w64_async_wdata", wdata_b, 64'd0);
    @(negedge clk);
    rst_b = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
